// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register with registered in_ready/out_valid.
// Optional synchronous flush port enabled by defining SKID_FLUSH_EN.
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             out_ready
);

  // state | meaning
  // EMPTY | no word held; main reg is stale
  // BUSY  | one word in main reg, presented on out_data
  // FULL  | main holds head, skid holds the next word; upstream stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        case ({accept, pop})
          2'b10: begin
            state_d = FULL;
            skid_d  = in_data;
          end
          2'b11: main_d = in_data;
          2'b01: state_d = EMPTY;
          default: state_d = BUSY;
        endcase
      end
      FULL: begin
        if (pop) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef SKID_FLUSH_EN
    // Flush wins over any accept/pop in the same cycle; data regs are don't-care.
    if (flush) begin
      state_d = EMPTY;
    end
`endif
  end

  // Handshake outputs are decoded from the next state so they come straight from flops.
  assign in_ready_d  = (state_d != FULL);
  assign out_valid_d = (state_d != EMPTY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: vector table, hand sequences,
// and a random run against a 2-deep queue reference model.
module tb_pipe_skid_buffer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef SKID_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;

  pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef SKID_FLUSH_EN
    .flush     (flush),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             exp_in_ready;
    logic             exp_out_valid;
    logic [WIDTH-1:0] exp_out_data;
    logic             chk_data;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] stall_word;
  logic acc, pp, stall;
  int sent, recv;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef SKID_FLUSH_EN
    flush = 1'b0;
`endif
    // in_valid, in_data, out_ready, exp_in_ready, exp_out_valid, exp_out_data, chk_data
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[4] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    tick(); tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      in_valid = vecs[i].in_valid; in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      tick();
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_in_ready));
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_out_valid));
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].exp_out_data));
    end

    // Async reset while FULL: outputs must clear without a clock edge.
    in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b0; tick();
    in_data = 8'h44; tick();
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_out_data", int'(out_data), 8'h33);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_data", int'(out_data), 0);
    #1 reset = 1'b1;

    // Streaming: one word per cycle with in_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      tick();
      chk($sformatf("stream%0d_out_valid", i), int'(out_valid), 1);
      chk($sformatf("stream%0d_out_data", i), int'(out_data), i);
      chk($sformatf("stream%0d_in_ready", i), int'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_out_valid", int'(out_valid), 0);

`ifdef SKID_FLUSH_EN
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33; tick();
    in_data = 8'h44; tick();
    chk("flushpre_in_ready", int'(in_ready), 0);
    flush = 1'b1; in_data = 8'h77; out_ready = 1'b1; tick();
    flush = 1'b0;
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    in_data = 8'h55; out_ready = 1'b0; tick();
    chk("postflush_out_data", int'(out_data), 8'h55);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("postflush_drain", int'(out_valid), 0);
`endif

    // Random traffic vs. a capacity-2 FIFO model.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      acc   = in_valid && (model.size() < 2);
      pp    = out_ready && (model.size() > 0);
      stall = (model.size() > 0) && !out_ready;
      stall_word = (model.size() > 0) ? model[0] : '0;
      tick();
      if (pp) begin
        void'(model.pop_front());
        recv++;
      end
      if (acc) begin
        model.push_back(in_data);
        sent++;
      end
      chk("rand_in_ready", int'(in_ready), int'(model.size() < 2));
      chk("rand_out_valid", int'(out_valid), int'(model.size() > 0));
      if (model.size() > 0) chk("rand_out_data", int'(out_data), int'(model[0]));
      if (stall) chk("rand_stall_stable", int'(out_data), int'(stall_word));
    end
    chk("rand_words_received", recv, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
